// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared state encoding, widths and helpers for the scoreboard slice
package scoreboard_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUNNING = 3'd1,
        PAUSED  = 3'd2,
        BREAK   = 3'd3,
        FINAL   = 3'd4
    } state_e;

    localparam int SHOT_CLOCK_MAX = 24;
    localparam int SHOT_W         = 6;
    localparam int SCORE_W        = 8;
    localparam int VIOL_W         = 4;

    // Violation counters stick at all-ones rather than wrapping.
    function automatic logic [VIOL_W-1:0] sat_inc(input logic [VIOL_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/buzzer_timer.sv
// rtl/buzzer_timer.sv - reloadable countdown that holds the buzzer on for BUZZ_SEC ticks
module buzzer_timer #(
    parameter int BUZZ_SEC = 3
) (
    input  logic clk_1Hz,
    input  logic rst,
    input  logic load,
    output logic active
);

    logic [2:0] cnt_q, cnt_d;
    logic       active_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = 3'(BUZZ_SEC);
        else if (cnt_q != 3'd0)
            cnt_d = cnt_q - 1'b1;
    end

    // active_q mirrors the post-edge count so the pin is a clean flop output.
    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            cnt_q    <= 3'd0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= (cnt_d != 3'd0);
        end
    end

    assign active = active_q;

endmodule

// File: rtl/game_clock_ctrl.sv
// rtl/game_clock_ctrl.sv - game clock, quarter sequencing, shot-clock violations and buzzer
module game_clock_ctrl
    import scoreboard_pkg::*;
#(
    parameter int QUARTER_MIN  = 10,
    parameter int BREAK_SEC    = 15,
    parameter int NUM_QUARTERS = 4,
    parameter int BUZZ_SEC     = 3
) (
    input  logic              clk_1Hz,
    input  logic              rst,
    input  logic              run,
    input  logic [SHOT_W-1:0] shot_clock,
    input  logic              team_a_poss,
    input  logic              team_b_poss,
    output logic [3:0]        game_min,
    output logic [5:0]        game_sec,
    output logic [2:0]        quarter,
    output logic [VIOL_W-1:0] viol_a,
    output logic [VIOL_W-1:0] viol_b,
    output logic              buzzer,
    output logic              game_over
);

    state_e            state_q;
    logic [3:0]        game_min_q;
    logic [5:0]        game_sec_q;
    logic [2:0]        quarter_q;
    logic [VIOL_W-1:0] viol_a_q, viol_b_q;
    logic [SHOT_W-1:0] shot_prev_q;
    logic [5:0]        brk_cnt_q;
    logic              game_over_q;

    logic running, violation, quarter_end, buzz_load;

    assign running     = (state_q == RUNNING);
    assign violation   = running && (shot_clock == '0) && (shot_prev_q != '0);
    // The decrement from 00:01 is the only way time reaches 00:00.
    assign quarter_end = running && run && (game_min_q == 4'd0) && (game_sec_q == 6'd1);
    assign buzz_load   = violation | quarter_end;

    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            game_min_q  <= 4'(QUARTER_MIN);
            game_sec_q  <= 6'd0;
            quarter_q   <= 3'd1;
            viol_a_q    <= '0;
            viol_b_q    <= '0;
            shot_prev_q <= SHOT_W'(SHOT_CLOCK_MAX);
            brk_cnt_q   <= 6'd0;
            game_over_q <= 1'b0;
        end else begin
            shot_prev_q <= shot_clock;
            if (violation) begin
                if (team_a_poss)
                    viol_a_q <= sat_inc(viol_a_q);
                else if (team_b_poss)
                    viol_b_q <= sat_inc(viol_b_q);
            end
            case (state_q)
                IDLE: if (run) state_q <= RUNNING;
                RUNNING: begin
                    if (!run) begin
                        state_q <= PAUSED;
                    end else begin
                        if (game_sec_q == 6'd0) begin
                            game_sec_q <= 6'd59;
                            game_min_q <= game_min_q - 1'b1;
                        end else begin
                            game_sec_q <= game_sec_q - 1'b1;
                        end
                        if (quarter_end) begin
                            if (quarter_q < 3'(NUM_QUARTERS)) begin
                                state_q   <= BREAK;
                                brk_cnt_q <= 6'(BREAK_SEC);
                            end else begin
                                state_q     <= FINAL;
                                game_over_q <= 1'b1;
                            end
                        end
                    end
                end
                PAUSED: if (run) state_q <= RUNNING;
                BREAK: begin
                    brk_cnt_q <= brk_cnt_q - 1'b1;
                    if (brk_cnt_q == 6'd1) begin
                        quarter_q  <= quarter_q + 1'b1;
                        game_min_q <= 4'(QUARTER_MIN);
                        game_sec_q <= 6'd0;
                        state_q    <= IDLE;
                    end
                end
                FINAL: game_over_q <= 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    end

    buzzer_timer #(
        .BUZZ_SEC(BUZZ_SEC)
    ) u_buzzer_timer (
        .clk_1Hz(clk_1Hz),
        .rst    (rst),
        .load   (buzz_load),
        .active (buzzer)
    );

    assign game_min  = game_min_q;
    assign game_sec  = game_sec_q;
    assign quarter   = quarter_q;
    assign viol_a    = viol_a_q;
    assign viol_b    = viol_b_q;
    assign game_over = game_over_q;

endmodule
